// File: rtl/serial_signed_or_unsigned_mul.sv
// Radix-2 shift-add multiplier, n cycles per product, signed or unsigned per request.
// Works on magnitudes and applies the sign once, when the product is registered.
module serial_signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res
);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [n-1:0]   mcand_q;
  logic [2*n-1:0] acc_q;
  logic           neg_q;
  logic           res_vld_q;
  logic [2*n-1:0] res_q;

  logic [n-1:0]   a_mag_d, b_mag_d;
  logic [n:0]     sum_d;
  logic [2*n-1:0] acc_d, prod_d;

  // abs of the most negative value wraps to 2^(n-1), which fits unsigned
  always_comb begin
    a_mag_d = (signed_mul && a[n-1]) ? (~a + 1'b1) : a;
    b_mag_d = (signed_mul && b[n-1]) ? (~b + 1'b1) : b;
    sum_d   = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, mcand_q} : {(n+1){1'b0}});
    acc_d   = {sum_d, acc_q[n-1:1]};
    prod_d  = neg_q ? (~acc_d + {{(2*n-1){1'b0}}, 1'b1}) : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (arg_vld) begin
          mcand_q <= a_mag_d;
          acc_q   <= {{n{1'b0}}, b_mag_d};
          neg_q   <= signed_mul & (a[n-1] ^ b[n-1]);
          cnt_q   <= CW'(n-1);
          state_q <= BUSY;
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          // last step: publish the signed-corrected product on the same edge
          if (cnt_q == '0) begin
            res_q     <= prod_d;
            res_vld_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: if (res_rdy) begin
          res_vld_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arg_rdy = (state_q == IDLE);
  assign res_vld = res_vld_q;
  assign res     = res_q;
endmodule

// File: tb/tb_serial_signed_or_unsigned_mul.sv
// Scoreboarded random + directed bench for the serial multiplier (n=8).
module tb_serial_signed_or_unsigned_mul;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arg_vld = 1'b0;
  logic           arg_rdy;
  logic [N-1:0]   a = '0, b = '0;
  logic           sm = 1'b0;
  logic           res_vld;
  logic           res_rdy = 1'b1;
  logic [2*N-1:0] res;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  serial_signed_or_unsigned_mul #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .signed_mul(sm), .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic s);
    longint xi, yi, p;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[N-1]) xi = xi - (longint'(1) << N);
    if (s && y[N-1]) yi = yi - (longint'(1) << N);
    p = xi * yi;
    return p[2*N-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every result handshake pops one expected product
  always @(negedge clk) begin
    if (rst_n && res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", res);
      end else begin
        chk("res", longint'(res), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                       input bit scramble);
    bit ok = 1'b0;
    a = x; b = y; sm = s; arg_vld = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = arg_rdy;
      @(posedge clk); #1;
    end
    arg_vld = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    exp_q.push_back(model(x, y, s));
    for (int c = 1; c <= N; c++) begin
      if (scramble) begin
        a = N'($urandom); b = N'($urandom); sm = 1'($urandom); arg_vld = 1'b1;
      end
      @(posedge clk); #1;
      chk("res_vld_latency", longint'(res_vld), (c == N) ? 1 : 0);
    end
    arg_vld = 1'b0;
    if (res_rdy) begin
      @(posedge clk); #1;
      chk("arg_rdy_after_res", longint'(arg_rdy), 1);
    end
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return N'(1);
      2: return {N{1'b1}};
      3: return {1'b1, {(N-1){1'b0}}};
      4: return {1'b0, {(N-1){1'b1}}};
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] hold_exp;
    #12;
    chk("reset_arg_rdy", longint'(arg_rdy), 1);
    chk("reset_res_vld", longint'(res_vld), 0);
    chk("reset_res", longint'(res), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'd255, 8'd255, 1'b0, 1'b0);   // 65025
    issue(8'h80, 8'h80, 1'b1, 1'b0);     // 16384
    issue(8'h80, 8'h7F, 1'b1, 1'b0);     // -16256
    issue(8'hFD, 8'h00, 1'b1, 1'b0);     // signed zero
    issue(8'd200, 8'd3, 1'b0, 1'b1);     // 600 with inputs churning

    // backpressure: result must hold, nothing accepted
    res_rdy = 1'b0;
    issue(8'hF3, 8'h11, 1'b1, 1'b0);
    hold_exp = model(8'hF3, 8'h11, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a = N'($urandom); b = N'($urandom); sm = 1'($urandom); arg_vld = 1'b1;
      @(posedge clk); #1;
      chk("bp_res_vld", longint'(res_vld), 1);
      chk("bp_arg_rdy", longint'(arg_rdy), 0);
      chk("bp_res", longint'(res), longint'(hold_exp));
    end
    res_rdy = 1'b1;
    issue(8'd5, 8'd6, 1'b0, 1'b0);

    // asynchronous reset in the middle of BUSY
    a = 8'd100; b = 8'd100; sm = 1'b0; arg_vld = 1'b1;
    @(negedge clk);
    chk("rst_pre_accept", longint'(arg_rdy), 1);
    @(posedge clk); #1; arg_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_res_vld", longint'(res_vld), 0);
    chk("rst_arg_rdy", longint'(arg_rdy), 1);
    chk("rst_res", longint'(res), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);     // 1

    for (int i = 0; i < 300; i++)
      issue(pick(), pick(), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
